// File: rtl/pattern_loader_if.sv
// Host-side load/readback handshakes plus the serial port towards patternbuffer.
// The slave modport is the loader's view; master is the host / pattern-buffer side.
interface pattern_loader_if #(
    parameter int buffer_width = 7
);
    logic                    load_valid;
    logic                    load_ready;
    logic [2:0]              load_addr;
    logic [buffer_width-1:0] load_data;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [buffer_width-1:0] rd_data;
    logic                    busy;
    logic                    sin;
    logic                    ssel;
    logic [2:0]              saddr;
    logic                    sout;

    modport master (
        output load_valid, load_addr, load_data, rd_ready, sout,
        input  load_ready, rd_valid, rd_data, busy, sin, ssel, saddr
    );

    modport slave (
        input  load_valid, load_addr, load_data, rd_ready, sout,
        output load_ready, rd_valid, rd_data, busy, sin, ssel, saddr
    );
endinterface

// File: rtl/pattern_loader.sv
// Serial frame loader/readback engine: collects one buffer of field words, shifts
// them out LSB-first as a single ssel frame and returns the captured sout bits as words.
module pattern_loader #(
    parameter int buffer_width = 7,
    parameter int buffer_size  = 22,
    parameter int sout_latency = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    pattern_loader_if.slave bus
);
    localparam int L    = buffer_width * buffer_size;
    localparam int WC_W = (buffer_size > 1) ? $clog2(buffer_size) : 1;
    localparam int BC_W = (L > 1) ? $clog2(L) : 1;
    localparam int DC_W = (sout_latency > 1) ? $clog2(sout_latency) : 1;
    localparam logic [WC_W-1:0] W_LAST = WC_W'(buffer_size - 1);
    localparam logic [BC_W-1:0] B_LAST = BC_W'(L - 1);
    localparam logic [DC_W-1:0] D_LAST = DC_W'(sout_latency - 1);

    typedef enum logic [2:0] {FILL, SETUP, SHIFT, DRAIN, READ} state_t;

    state_t          state, state_d;
    logic [WC_W-1:0] wcnt, wcnt_d;
    logic [BC_W-1:0] bcnt, bcnt_d;
    logic [DC_W-1:0] dcnt, dcnt_d;
    logic            ld_fire;
    logic [2:0]      addr_lat;

    // Flat frame images: bit k of the vector is frame bit k (word k/bw, bit k%bw).
    logic [L-1:0] ld_bits;
    logic [L-1:0] rb_bits;

    logic [sout_latency-1:0]           vld_pipe;
    logic [sout_latency-1:0][BC_W-1:0] idx_pipe;

    assign bus.load_ready = (state == FILL);
    assign bus.rd_valid   = (state == READ);
    assign bus.busy       = (state != FILL);
    assign bus.rd_data    = rb_bits[int'(wcnt)*buffer_width +: buffer_width];

    always_comb begin
        state_d = state;
        wcnt_d  = wcnt;
        bcnt_d  = bcnt;
        dcnt_d  = dcnt;
        ld_fire = 1'b0;
        unique case (state)
            FILL: begin
                if (bus.load_valid) begin
                    ld_fire = 1'b1;
                    if (wcnt == W_LAST) begin
                        wcnt_d  = '0;
                        state_d = SETUP;
                    end else begin
                        wcnt_d = wcnt + 1'b1;
                    end
                end
            end
            SETUP: begin
                bcnt_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bcnt == B_LAST) begin
                    bcnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end else begin
                    bcnt_d = bcnt + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == D_LAST) begin
                    dcnt_d  = '0;
                    state_d = READ;
                end else begin
                    dcnt_d = dcnt + 1'b1;
                end
            end
            READ: begin
                if (bus.rd_ready) begin
                    if (wcnt == W_LAST) begin
                        wcnt_d  = '0;
                        state_d = FILL;
                    end else begin
                        wcnt_d = wcnt + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            wcnt  <= '0;
            bcnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_d;
            wcnt  <= wcnt_d;
            bcnt  <= bcnt_d;
            dcnt  <= dcnt_d;
        end
    end

    // Serial outputs are registered from next-state so SHIFT cycle k carries bit k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_bits   <= '0;
            addr_lat  <= '0;
            bus.sin   <= 1'b0;
            bus.ssel  <= 1'b0;
            bus.saddr <= '0;
        end else begin
            if (ld_fire) begin
                ld_bits[int'(wcnt)*buffer_width +: buffer_width] <= bus.load_data;
                if (wcnt == '0)
                    addr_lat <= bus.load_addr;
            end
            if (state_d == SETUP)
                bus.saddr <= addr_lat;
            bus.ssel <= (state_d == SHIFT);
            bus.sin  <= (state_d == SHIFT) && ld_bits[bcnt_d];
        end
    end

    // Capture runs off a delayed ssel/bcnt, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
            rb_bits  <= '0;
        end else begin
            vld_pipe[0] <= bus.ssel;
            idx_pipe[0] <= bcnt;
            for (int i = 1; i < sout_latency; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
            if (vld_pipe[sout_latency-1])
                rb_bits[idx_pipe[sout_latency-1]] <= bus.sout;
        end
    end
endmodule

// File: tb/tb_pattern_loader.sv
// Randomised bench for pattern_loader: a negedge monitor plays the pattern buffer and
// logs the serial port; frames are checked against word/bit arithmetic from that log.
module tb_pattern_loader;
    localparam int BW   = 7;
    localparam int BS   = 22;
    localparam int LAT  = 3;
    localparam int L    = BW * BS;
    localparam int MASK = 8191;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pattern_loader_if #(.buffer_width(BW)) bus();

    pattern_loader #(
        .buffer_width(BW),
        .buffer_size (BS),
        .sout_latency(LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor / pattern-buffer model state
    int            mcyc = 0;
    int            sout_mode = 0;   // 0 loopback, 1 const1, 2 const0, 3 random
    logic          sin_log  [0:MASK];
    logic          sout_log [0:MASK];
    int            xfer_cnt, last_acc, ssel_start, ssel_len, ssel_rises, first_rd, post_cnt, saddr_bad;
    logic [2:0]    saddr_rise, saddr_prev;
    logic          ssel_prev, rv_prev, rr_prev;
    logic [BW-1:0] rd_prev;
    logic [BW-1:0] rd_q[$];
    logic          fbits[$];
    logic [BW-1:0] words[BS];

    always @(negedge clk) begin
        sin_log[mcyc & MASK] = bus.sin;
        case (sout_mode)
            0:       bus.sout = (mcyc >= LAT) ? sin_log[(mcyc - LAT) & MASK] : 1'b0;
            1:       bus.sout = 1'b1;
            2:       bus.sout = 1'b0;
            default: bus.sout = 1'($urandom);
        endcase
        sout_log[mcyc & MASK] = bus.sout;
        if (bus.load_valid && bus.load_ready) begin
            xfer_cnt++;
            last_acc = mcyc;
        end
        if (bus.ssel && !ssel_prev) begin
            ssel_rises++;
            ssel_start = mcyc;
            saddr_rise = bus.saddr;
            if (saddr_prev !== bus.saddr) saddr_bad++;
        end
        if ((bus.ssel || post_cnt > 0) && bus.saddr !== saddr_rise) saddr_bad++;
        if (bus.ssel) begin
            ssel_len++;
            fbits.push_back(bus.sin);
            post_cnt = LAT;
        end else if (post_cnt > 0) begin
            post_cnt--;
        end
        if (bus.rd_valid && !rv_prev) first_rd = mcyc;
        if (bus.rd_valid && rv_prev && !rr_prev)
            chk("rd_stall_stable", 32'(bus.rd_data), 32'(rd_prev));
        if (bus.rd_valid && bus.rd_ready) rd_q.push_back(bus.rd_data);
        ssel_prev  = bus.ssel;
        rv_prev    = bus.rd_valid;
        rr_prev    = bus.rd_ready;
        rd_prev    = bus.rd_data;
        saddr_prev = bus.saddr;
        mcyc++;
    end

    task automatic clr_mon();
        xfer_cnt = 0; last_acc = -1; ssel_len = 0; ssel_rises = 0; ssel_start = 0;
        first_rd = -1; post_cnt = 0; saddr_bad = 0; saddr_rise = '0;
        fbits.delete();
        rd_q.delete();
    endtask

    task automatic send_words(input logic [2:0] addr);
        for (int i = 0; i < BS; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            bus.load_addr  = (i == 0) ? addr : 3'($urandom);
            @(posedge clk); #1;
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [2:0] addr, input int mode,
                             input int rdy_mode, input bit hold);
        int            n;
        logic [BW-1:0] gw, ew;
        sout_mode = mode;
        clr_mon();
        send_words(addr);
        bus.load_valid = hold;
        n = 0;
        while (!bus.rd_valid && n < 400) begin
            if (hold) begin
                bus.load_data = BW'($urandom);
                bus.load_addr = 3'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        bus.load_valid = 1'b0;
        chk({nm, "_rd_wait"}, 32'(n < 400), 32'd1);
        for (int c = 0; rd_q.size() < BS && c < 600; c++) begin
            case (rdy_mode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = (c % 4 == 0) || (c % 4 == 3);
                default: bus.rd_ready = 1'($urandom);
            endcase
            @(posedge clk); #1;
        end
        bus.rd_ready = 1'b0;
        chk({nm, "_xfers"}, 32'(xfer_cnt), 32'(BS));
        chk({nm, "_ssel_len"}, 32'(ssel_len), 32'(L));
        chk({nm, "_ssel_rises"}, 32'(ssel_rises), 32'd1);
        chk({nm, "_saddr"}, 32'(saddr_rise), 32'(addr));
        chk({nm, "_saddr_stable"}, 32'(saddr_bad), 32'd0);
        chk({nm, "_latency"}, 32'(first_rd - last_acc - 1), 32'(1 + L + LAT));
        chk({nm, "_rd_count"}, 32'(rd_q.size()), 32'(BS));
        for (int w = 0; w < BS; w++) begin
            gw = '0;
            ew = '0;
            for (int b = 0; b < BW; b++) begin
                if (fbits.size() == L) gw[b] = fbits[w*BW + b];
                ew[b] = sout_log[(ssel_start + w*BW + b + LAT) & MASK];
            end
            chk($sformatf("%s_sin_w%0d", nm, w), 32'(gw), 32'(words[w]));
            if (w < rd_q.size()) begin
                chk($sformatf("%s_rb_w%0d", nm, w), 32'(rd_q[w]), 32'(ew));
                if (mode == 0) chk($sformatf("%s_loop_w%0d", nm, w), 32'(rd_q[w]), 32'(words[w]));
                if (mode == 1) chk($sformatf("%s_ones_w%0d", nm, w), 32'(rd_q[w]), 32'h7f);
                if (mode == 2) chk($sformatf("%s_zero_w%0d", nm, w), 32'(rd_q[w]), 32'h00);
            end
        end
        chk({nm, "_idle_ready"}, 32'(bus.load_ready), 32'd1);
        chk({nm, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_load_ready"}, 32'(bus.load_ready), 32'd1);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({nm, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        chk({nm, "_sin"}, 32'(bus.sin), 32'd0);
        chk({nm, "_ssel"}, 32'(bus.ssel), 32'd0);
        chk({nm, "_saddr"}, 32'(bus.saddr), 32'd0);
    endtask

    task automatic rand_words();
        for (int i = 0; i < BS; i++) words[i] = BW'($urandom);
    endtask

    initial begin
        int n;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_addr  = '0;
        bus.rd_ready   = 1'b0;
        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < BS; i++) words[i] = BW'(i + 1);
        run_frame("seq", 3'd5, 0, 0, 1'b0);

        for (int i = 0; i < BS; i++) words[i] = '0;
        words[0] = 7'h55;
        run_frame("h55", 3'($urandom), 0, 0, 1'b0);

        rand_words();
        run_frame("ones", 3'($urandom), 1, 0, 1'b0);
        rand_words();
        run_frame("zeros", 3'($urandom), 2, 2, 1'b0);
        rand_words();
        run_frame("hold", 3'($urandom), 3, 2, 1'b1);
        rand_words();
        run_frame("stall", 3'($urandom), 0, 1, 1'b0);

        // Abort a frame at SHIFT cycle 40
        rand_words();
        sout_mode = 0;
        clr_mon();
        send_words(3'd6);
        n = 0;
        while (ssel_len < 40 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_wait", 32'(n < 300), 32'd1);
        chk("abort_ssel_before", 32'(bus.ssel), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_release_ready", 32'(bus.load_ready), 32'd1);

        rand_words();
        run_frame("after_abort", 3'($urandom), 0, 2, 1'b0);
        rand_words();
        run_frame("rnd_a", 3'($urandom), 3, 1, 1'b1);
        rand_words();
        run_frame("rnd_b", 3'($urandom), 0, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
